sumhsq_param_bank: RTL and testbench

- Avalon-MM writable register bank that drives NUM_CH parameter words, one per SUMHSQ channel, to the sum-of-squares datapath.
- Software writes shadow registers, then requests a commit. All live outputs update atomically at the next sync_point, between ultrasonic acquisition frames, or immediately in immediate mode.
- Signals completion with a strobe, a commit counter and a maskable interrupt.

---
 rtl/sumhsq_param_bank.sv | 155 +++++++++++++++
 tb/tb_sumhsq_param_bank.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumhsq_param_bank.sv
// Shadow/live parameter bank for the SUMHSQ channels, committed at frame sync.
// Optional live-word readback is compiled in with SUMHSQ_LIVE_READBACK_EN.
module sumhsq_param_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     sync_point,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     upd_strobe,
  output logic                     irq
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CH + 1);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shadow [NUM_CH];
  logic [DATA_W-1:0] r_live   [NUM_CH];
  logic              r_imm;
  logic              r_irq_en;
  logic              r_irq_flag;
  logic [7:0]        r_cnt;
  logic              r_strobe;

  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_stat_wr;
  logic              w_commit;
  logic              w_cancel;
  logic              w_pending;
  logic              w_xfer;
  logic [31:0]       w_rdata;
  logic              w_unused_wd;

  assign w_wr      = chipselect & ~write_n;
  assign w_ctrl_wr = w_wr & (address == A_CTRL);
  assign w_stat_wr = w_wr & (address == A_STAT);
  assign w_cancel  = w_ctrl_wr & writedata[2];
  assign w_commit  = w_ctrl_wr & writedata[0]
                   & ~writedata[2];
  assign w_pending = (r_state == S_PEND);

  // Cancel beats both sync_point and immediate mode.
  assign w_xfer = w_pending & ~w_cancel
                & (sync_point | r_imm);

  assign w_unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_commit)
            r_state <= S_PEND;
        end
        S_PEND: begin
          if (w_cancel || w_xfer)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++)
        r_shadow[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_wr && address == ADDR_W'(i))
          r_shadow[i] <= writedata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++)
        r_live[i] <= RESET_VAL;
    end else if (w_xfer) begin
      for (int i = 0; i < NUM_CH; i++)
        r_live[i] <= r_shadow[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_imm    <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_imm    <= writedata[1];
      r_irq_en <= writedata[3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_flag <= 1'b0;
      r_cnt      <= 8'd0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= w_xfer;
      if (w_xfer) begin
        r_irq_flag <= 1'b1;
        r_cnt      <= r_cnt + 8'd1;
      end else if (w_stat_wr && writedata[1]) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (address == ADDR_W'(i))
        w_rdata[DATA_W-1:0] = r_shadow[i];
    if (address == A_CTRL)
      w_rdata = {28'b0, r_irq_en, 1'b0,
                 r_imm, 1'b0};
    if (address == A_STAT)
      w_rdata = {16'b0, r_cnt, 6'b0,
                 r_irq_flag, w_pending};
`ifdef SUMHSQ_LIVE_READBACK_EN
    for (int i = 0; i < NUM_CH; i++)
      if (address == ADDR_W'(NUM_CH + 2 + i))
        w_rdata[DATA_W-1:0] = r_live[i];
`endif
  end

  assign readdata = w_rdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = r_live[g];
  end

  assign upd_strobe = r_strobe;
  assign irq        = r_irq_flag & r_irq_en;

endmodule

// File: tb/tb_sumhsq_param_bank.sv
// Directed bench for sumhsq_param_bank with default parameters.
// Readback expectations follow SUMHSQ_LIVE_READBACK_EN.
module tb_sumhsq_param_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        sync_point = 1'b0;
  logic [95:0] out_port;
  logic        upd_strobe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  sumhsq_param_bank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sync_point (sync_point),
    .out_port   (out_port),
    .upd_strobe (upd_strobe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [3:0] a,
                        input logic [31:0] d,
                        input logic s);
    @(negedge clk);
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    sync_point = s;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    sync_point = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a,
                        output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      bus_rd(4'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd[%0d]: got %h exp 0", a, d);
      end
    end
    checks++;
    if (out_port !== 96'h0 || irq !== 1'b0 || upd_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out=%h irq=%b stb=%b exp 0",
               out_port, irq, upd_strobe);
    end
  endtask

  task automatic test_sync_commit;
    logic [31:0] d;
    logic seen_stb;
    bus_wr(4'd0, 32'h00123456, 1'b0);
    bus_wr(4'd3, 32'h00ABCDEF, 1'b0);
    bus_wr(4'd4, 32'h1, 1'b0);
    seen_stb = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_stb |= upd_strobe;
    end
    checks++;
    if (out_port !== 96'h0 || seen_stb !== 1'b0) begin
      errors++;
      $display("FAIL hold_out: out=%h stb=%b exp 0", out_port, seen_stb);
    end
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0001) begin
      errors++;
      $display("FAIL hold_status: got %h exp 00000001", d);
    end
    sync_point = 1'b1;
    @(negedge clk);
    sync_point = 1'b0;
    checks++;
    if (out_port[23:0] !== 24'h123456 || out_port[95:72] !== 24'hABCDEF) begin
      errors++;
      $display("FAIL sync_live: got %h exp ch0=123456 ch3=abcdef", out_port);
    end
    checks++;
    if (upd_strobe !== 1'b1) begin
      errors++;
      $display("FAIL sync_stb: got %b exp 1", upd_strobe);
    end
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0102) begin
      errors++;
      $display("FAIL sync_status: got %h exp 00000102", d);
    end
    @(negedge clk);
    checks++;
    if (upd_strobe !== 1'b0) begin
      errors++;
      $display("FAIL sync_stb_end: got %b exp 0", upd_strobe);
    end
  endtask

  task automatic test_imm_irq;
    logic [31:0] d;
    bus_wr(4'd4, 32'h0A, 1'b0);
    bus_wr(4'd1, 32'h0000FF00, 1'b0);
    bus_wr(4'd4, 32'h0B, 1'b0);
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0103 || out_port[47:24] !== 24'h0) begin
      errors++;
      $display("FAIL imm_pend: st=%h ch1=%h exp 00000103/0",
               d, out_port[47:24]);
    end
    @(negedge clk);
    checks++;
    if (out_port[47:24] !== 24'h00FF00 || upd_strobe !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL imm_live: ch1=%h stb=%b irq=%b exp 00ff00/1/1",
               out_port[47:24], upd_strobe, irq);
    end
    bus_rd(4'd4, d);
    checks++;
    if (d !== 32'h0A) begin
      errors++;
      $display("FAIL ctrl_rd: got %h exp 0000000a", d);
    end
    bus_wr(4'd5, 32'h2, 1'b0);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b exp 0", irq);
    end
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0200) begin
      errors++;
      $display("FAIL clr_status: got %h exp 00000200", d);
    end
  endtask

  task automatic test_cancel;
    logic [31:0] d;
    bus_wr(4'd0, 32'h00111111, 1'b0);
    bus_wr(4'd4, 32'h1, 1'b0);
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0201) begin
      errors++;
      $display("FAIL cancel_pend: got %h exp 00000201", d);
    end
    bus_wr(4'd4, 32'h4, 1'b1);
    checks++;
    if (upd_strobe !== 1'b0) begin
      errors++;
      $display("FAIL cancel_stb: got %b exp 0", upd_strobe);
    end
    checks++;
    if (out_port !== 96'hABCDEF_000000_00FF00_123456) begin
      errors++;
      $display("FAIL cancel_out: got %h exp abcdef00000000ff00123456",
               out_port);
    end
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0200) begin
      errors++;
      $display("FAIL cancel_status: got %h exp 00000200", d);
    end
  endtask

  task automatic test_shadow_race;
    logic [31:0] d;
    bus_wr(4'd2, 32'h000000AA, 1'b0);
    bus_wr(4'd4, 32'h1, 1'b0);
    bus_wr(4'd2, 32'h000000BB, 1'b1);
    checks++;
    if (out_port[71:48] !== 24'h0000AA || out_port[23:0] !== 24'h111111) begin
      errors++;
      $display("FAIL race_old: ch2=%h ch0=%h exp 0000aa/111111",
               out_port[71:48], out_port[23:0]);
    end
    bus_rd(4'd2, d);
    checks++;
    if (d !== 32'hBB) begin
      errors++;
      $display("FAIL race_shadow: got %h exp 000000bb", d);
    end
    bus_wr(4'd4, 32'h1, 1'b0);
    sync_point = 1'b1;
    @(negedge clk);
    sync_point = 1'b0;
    checks++;
    if (out_port[71:48] !== 24'h0000BB) begin
      errors++;
      $display("FAIL race_new: got %h exp 0000bb", out_port[71:48]);
    end
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0402) begin
      errors++;
      $display("FAIL race_status: got %h exp 00000402", d);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    repeat (251) begin
      bus_wr(4'd4, 32'h3, 1'b0);
      @(negedge clk);
    end
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'hFF02) begin
      errors++;
      $display("FAIL cnt_255: got %h exp 0000ff02", d);
    end
    bus_wr(4'd4, 32'h3, 1'b0);
    @(negedge clk);
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0002) begin
      errors++;
      $display("FAIL cnt_wrap: got %h exp 00000002", d);
    end
  endtask

  task automatic test_readback;
    logic [31:0] d;
    logic [31:0] exp_rb;
`ifdef SUMHSQ_LIVE_READBACK_EN
    exp_rb = 32'h00111111;
`else
    exp_rb = 32'h0;
`endif
    bus_rd(4'd6, d);
    checks++;
    if (d !== exp_rb) begin
      errors++;
      $display("FAIL readback: got %h exp %h", d, exp_rb);
    end
    bus_wr(4'd6, 32'h00555555, 1'b0);
    bus_wr(4'd12, 32'h00666666, 1'b0);
    bus_rd(4'd12, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_rd: got %h exp 0", d);
    end
    bus_rd(4'd0, d);
    checks++;
    if (d !== 32'h00111111 || out_port[23:0] !== 24'h111111) begin
      errors++;
      $display("FAIL unmapped_wr: sh0=%h ch0=%h exp 111111",
               d, out_port[23:0]);
    end
  endtask

  task automatic test_reset_pending;
    logic [31:0] d;
    bus_wr(4'd0, 32'h00777777, 1'b0);
    bus_wr(4'd4, 32'h1, 1'b0);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    sync_point = 1'b1;
    @(negedge clk);
    sync_point = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd(4'd5, d);
    checks++;
    if (d !== 32'h0 || out_port !== 96'h0 || upd_strobe !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend: st=%h out=%h stb=%b exp 0",
               d, out_port, upd_strobe);
    end
  endtask

  initial begin
    test_reset();
    test_sync_commit();
    test_imm_irq();
    test_cancel();
    test_shadow_race();
    test_wrap();
    test_readback();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
